// File: rtl/acc_dbuf_stream_shell.sv
// acc_dbuf_stream_shell: accelerator shell with a ping-pong operand buffer.
// Operands arrive either as a serial valid/ready word stream or as one wide
// forward bus beat. The shell starts an external core with a one-cycle pulse,
// captures its result vector and returns it either word by word or as one
// wide forward beat.
// Optional build macro ACC_SHELL_TIMEOUT_EN adds a core watchdog. The watchdog
// drops a job whose core_done does not arrive within TIMEOUT_CYCLES wait cycles.
module acc_dbuf_stream_shell #(
  parameter int DATA_W         = 64,
  parameter int NUM_IN         = 4,
  parameter int NUM_OUT        = 18,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_in_stream,
  input  logic                      cfg_out_stream,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      fwd_in_valid,
  output logic                      fwd_in_ready,
  input  logic [NUM_IN*DATA_W-1:0]  fwd_in_data,
  output logic                      core_start,
  output logic [NUM_IN*DATA_W-1:0]  core_data,
  input  logic                      core_done,
  input  logic [NUM_OUT*DATA_W-1:0] core_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic                      fwd_out_valid,
  input  logic                      fwd_out_ready,
  output logic [NUM_OUT*DATA_W-1:0] fwd_out_data,
  output logic                      err_timeout,
  output logic [15:0]               job_count
);

  localparam int IN_CW  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int OUT_CW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(NUM_IN - 1);
  localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(NUM_OUT - 1);

  typedef enum logic [1:0] {C_IDLE, C_START, C_WAIT, C_PRODUCE} core_state_e;

  logic [DATA_W-1:0] buf_q [2][NUM_IN];
  logic [DATA_W-1:0] buf_d [2][NUM_IN];
  logic [1:0]        buf_full_q, buf_full_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [IN_CW-1:0]  in_cnt_q, in_cnt_d;

  core_state_e       state_q, state_d;
  logic              out_mode_q, out_mode_d;
  logic [OUT_CW-1:0] out_cnt_q, out_cnt_d;
  logic [DATA_W-1:0] res_q [NUM_OUT];
  logic [DATA_W-1:0] res_d [NUM_OUT];
  logic [15:0]       job_count_q, job_count_d;

  logic wr_empty;
  logic in_fire;
  logic fwd_in_fire;
  logic release_buf;
  logic timeout_hit;

  // A serial fill in progress (in_cnt != 0) already implies serial mode was
  // latched at word 0, so the live pin only matters at a word-0 boundary.
  assign wr_empty     = !buf_full_q[wr_sel_q];
  assign in_ready     = wr_empty && ((in_cnt_q != '0) || cfg_in_stream);
  assign fwd_in_ready = wr_empty && (in_cnt_q == '0) && !cfg_in_stream;
  assign in_fire      = in_valid && in_ready;
  assign fwd_in_fire  = fwd_in_valid && fwd_in_ready;

  // Fill side: write the wr_sel buffer and merge set/clear of the full flags.
  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    wr_sel_d   = wr_sel_q;
    in_cnt_d   = in_cnt_q;
    if (release_buf) begin
      buf_full_d[rd_sel_q] = 1'b0;
    end
    if (in_fire) begin
      buf_d[wr_sel_q][in_cnt_q] = in_data;
      if (in_cnt_q == IN_LAST) begin
        buf_full_d[wr_sel_q] = 1'b1;
        wr_sel_d             = !wr_sel_q;
        in_cnt_d             = '0;
      end else begin
        in_cnt_d = in_cnt_q + IN_CW'(1);
      end
    end else if (fwd_in_fire) begin
      for (int k = 0; k < NUM_IN; k++) begin
        buf_d[wr_sel_q][k] = fwd_in_data[k*DATA_W +: DATA_W];
      end
      buf_full_d[wr_sel_q] = 1'b1;
      wr_sel_d             = !wr_sel_q;
    end
  end

  // Fill-side registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < NUM_IN; k++) begin
          buf_q[b][k] <= '0;
        end
      end
      buf_full_q <= '0;
      wr_sel_q   <= 1'b0;
      in_cnt_q   <= '0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      wr_sel_q   <= wr_sel_d;
      in_cnt_q   <= in_cnt_d;
    end
  end

  // Core FSM next state, result capture, output counter and buffer release.
  always_comb begin
    state_d     = state_q;
    out_mode_d  = out_mode_q;
    out_cnt_d   = out_cnt_q;
    res_d       = res_q;
    job_count_d = job_count_q;
    rd_sel_d    = rd_sel_q;
    release_buf = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (buf_full_q[rd_sel_q]) begin
          state_d = C_START;
        end
      end
      C_START: begin
        out_mode_d = cfg_out_stream;
        out_cnt_d  = '0;
        state_d    = C_WAIT;
      end
      C_WAIT: begin
        if (core_done) begin
          for (int i = 0; i < NUM_OUT; i++) begin
            res_d[i] = core_result[i*DATA_W +: DATA_W];
          end
          release_buf = 1'b1;
          rd_sel_d    = !rd_sel_q;
          state_d     = C_PRODUCE;
        end else if (timeout_hit) begin
          release_buf = 1'b1;
          rd_sel_d    = !rd_sel_q;
          state_d     = C_IDLE;
        end
      end
      C_PRODUCE: begin
        if (out_mode_q) begin
          if (out_ready) begin
            if (out_cnt_q == OUT_LAST) begin
              out_cnt_d   = '0;
              job_count_d = job_count_q + 16'd1;
              state_d     = C_IDLE;
            end else begin
              out_cnt_d = out_cnt_q + OUT_CW'(1);
            end
          end
        end else if (fwd_out_ready) begin
          job_count_d = job_count_q + 16'd1;
          state_d     = C_IDLE;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  // Core FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= C_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Core-side datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_mode_q  <= 1'b0;
      out_cnt_q   <= '0;
      job_count_q <= '0;
      rd_sel_q    <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      out_mode_q  <= out_mode_d;
      out_cnt_q   <= out_cnt_d;
      job_count_q <= job_count_d;
      rd_sel_q    <= rd_sel_d;
      res_q       <= res_d;
    end
  end

`ifdef ACC_SHELL_TIMEOUT_EN
  localparam int WAIT_CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_CW-1:0] WAIT_LAST = WAIT_CW'(TIMEOUT_CYCLES - 1);

  logic [WAIT_CW-1:0] wait_cnt_q, wait_cnt_d;
  logic               err_timeout_q, err_timeout_d;

  // A core_done in the final wait cycle still wins over the timeout.
  assign timeout_hit = (state_q == C_WAIT) && !core_done && (wait_cnt_q == WAIT_LAST);
  assign err_timeout = err_timeout_q;

  // Wait counter clears in C_START and counts every C_WAIT cycle.
  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    err_timeout_d = err_timeout_q || timeout_hit;
    if (state_q == C_START) begin
      wait_cnt_d = '0;
    end else if (state_q == C_WAIT) begin
      wait_cnt_d = wait_cnt_q + WAIT_CW'(1);
    end
  end

  // Watchdog registers; err_timeout stays set until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  for (genvar k = 0; k < NUM_IN; k++) begin : g_core_data
    assign core_data[k*DATA_W +: DATA_W] = buf_q[rd_sel_q][k];
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_fwd_out
    assign fwd_out_data[i*DATA_W +: DATA_W] = res_q[i];
  end

  assign core_start    = (state_q == C_START);
  assign out_valid     = (state_q == C_PRODUCE) && out_mode_q;
  assign out_data      = res_q[out_cnt_q];
  assign out_last      = out_valid && (out_cnt_q == OUT_LAST);
  assign fwd_out_valid = (state_q == C_PRODUCE) && !out_mode_q;
  assign job_count     = job_count_q;

endmodule

// File: tb/tb_acc_dbuf_stream_shell.sv
// tb_acc_dbuf_stream_shell: directed bench for acc_dbuf_stream_shell.
// A small core model answers each start pulse with result words derived from
// operand word 0, so every job's results are distinguishable and predictable.
module tb_acc_dbuf_stream_shell;

  localparam int DATA_W  = 64;
  localparam int NUM_IN  = 4;
  localparam int NUM_OUT = 18;
  localparam int BOUND   = 2000;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      cfg_in_stream = 1'b1;
  logic                      cfg_out_stream = 1'b1;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data = '0;
  logic                      fwd_in_valid = 1'b0;
  logic                      fwd_in_ready;
  logic [NUM_IN*DATA_W-1:0]  fwd_in_data = '0;
  logic                      core_start;
  logic [NUM_IN*DATA_W-1:0]  core_data;
  logic                      core_done = 1'b0;
  logic [NUM_OUT*DATA_W-1:0] core_result = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;
  logic                      fwd_out_valid;
  logic                      fwd_out_ready = 1'b0;
  logic [NUM_OUT*DATA_W-1:0] fwd_out_data;
  logic                      err_timeout;
  logic [15:0]               job_count;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int ready_mode = 1;
  int core_delay = 5;
  bit core_respond = 1'b1;

  logic [DATA_W-1:0] hs_data [$];
  bit                hs_last [$];
  int                hs_cyc [$];
  int                start_cyc_q [$];
  int                done_cyc_q [$];

  acc_dbuf_stream_shell #(
    .DATA_W(DATA_W), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_in_stream(cfg_in_stream), .cfg_out_stream(cfg_out_stream),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fwd_in_valid(fwd_in_valid), .fwd_in_ready(fwd_in_ready), .fwd_in_data(fwd_in_data),
    .core_start(core_start), .core_data(core_data),
    .core_done(core_done), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .fwd_out_valid(fwd_out_valid), .fwd_out_ready(fwd_out_ready), .fwd_out_data(fwd_out_data),
    .err_timeout(err_timeout), .job_count(job_count)
  );

  always #5 clk = ~clk;

  // Free-running cycle number used to timestamp handshakes and core events.
  always @(posedge clk) cyc <= cyc + 1;

  // Output ready pattern: 0 = low, 1 = high, 2 = toggle every cycle.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ~out_ready;
    endcase
  end

  // Record every serial output handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      hs_data.push_back(out_data);
      hs_last.push_back(out_last);
      hs_cyc.push_back(cyc);
    end
  end

  // Core model: result word i = ((operand0 - 0x11) << 16) + 0x100 + i.
  always begin
    logic [DATA_W-1:0] op0;
    @(negedge clk);
    if (core_start) begin
      start_cyc_q.push_back(cyc);
      if (core_respond) begin
        op0 = core_data[DATA_W-1:0];
        repeat (core_delay) @(posedge clk);
        #1;
        for (int i = 0; i < NUM_OUT; i++) begin
          core_result[i*DATA_W +: DATA_W] = ((op0 - 64'h11) << 16) + 64'h100 + 64'(i);
        end
        core_done = 1'b1;
        done_cyc_q.push_back(cyc);
        @(posedge clk);
        #1;
        core_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Send nwords serial words base*(k+1), waiting (bounded) for in_ready.
  task automatic apply_stimulus(input logic [63:0] base, input int nwords);
    for (int k = 0; k < nwords; k++) begin
      int t = 0;
      in_valid = 1'b1;
      in_data  = base * 64'(k + 1);
      while (!in_ready && t < BOUND) begin
        @(posedge clk);
        #1;
        t++;
      end
      check_output($sformatf("in_ready_w%0d", k), in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    int t = 0;
    while (hs_data.size() < target && t < BOUND) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_output("hs_count", hs_data.size(), target);
  endtask

  task automatic wait_start();
    int t = 0;
    while (!core_start && t < BOUND) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_output("core_start_seen", core_start, 1);
  endtask

  task automatic check_job(input string tag, input int base, input logic [63:0] tag_val);
    for (int i = 0; i < NUM_OUT; i++) begin
      if (base + i < hs_data.size()) begin
        check_output($sformatf("%s_d%0d", tag, i), hs_data[base+i], tag_val + 64'h100 + 64'(i));
        check_output($sformatf("%s_l%0d", tag, i), hs_last[base+i], (i == NUM_OUT - 1));
      end
    end
  endtask

  initial begin
    int hbase;
    int dbase;
    int sbase;
    int exp_jobs;
    int t;
    exp_jobs = 0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_core_start", core_start, 0);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_fwd_out_valid", fwd_out_valid, 0);
    check_output("rst_job_count", job_count, 0);
    check_output("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Serial job, core delay 5, out_ready high.
    hbase = hs_data.size();
    dbase = done_cyc_q.size();
    apply_stimulus(64'h11, NUM_IN);
    check_output("t1_start_t1", core_start, 0);
    @(posedge clk);
    #1;
    check_output("t1_start_t2", core_start, 1);
    for (int k = 0; k < NUM_IN; k++) begin
      check_output($sformatf("t1_core_data%0d", k), core_data[k*DATA_W +: DATA_W], 64'h11 * 64'(k + 1));
    end
    @(posedge clk);
    #1;
    check_output("t1_start_pulse", core_start, 0);
    wait_hs(hbase + NUM_OUT);
    check_job("t1", hbase, 64'h0);
    if (done_cyc_q.size() > dbase && hs_data.size() > hbase) begin
      check_output("t1_valid_lat", 64'(hs_cyc[hbase] - done_cyc_q[dbase]), 1);
    end
    @(posedge clk);
    #1;
    exp_jobs++;
    check_output("t1_job_count", job_count, 16'(exp_jobs));

    // Forward in / forward out with a 10-cycle ready stall.
    cfg_in_stream  = 1'b0;
    cfg_out_stream = 1'b0;
    #1;
    check_output("t2_in_ready_low", in_ready, 0);
    for (int k = 0; k < NUM_IN; k++) begin
      fwd_in_data[k*DATA_W +: DATA_W] = 64'h55 * 64'(k + 1);
    end
    fwd_in_valid = 1'b1;
    t = 0;
    while (!fwd_in_ready && t < BOUND) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_output("t2_fwd_in_ready", fwd_in_ready, 1);
    @(posedge clk);
    #1;
    fwd_in_valid  = 1'b0;
    cfg_in_stream = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cfg_out_stream = 1'b1;
    t = 0;
    while (!fwd_out_valid && t < BOUND) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_output("t2_fwd_out_valid", fwd_out_valid, 1);
    for (int i = 0; i < NUM_OUT; i++) begin
      check_output($sformatf("t2_fwd_d%0d", i), fwd_out_data[i*DATA_W +: DATA_W], 64'h440100 + 64'(i));
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("t2_hold_v%0d", c), fwd_out_valid, 1);
      check_output($sformatf("t2_hold_d%0d", c), fwd_out_data[DATA_W-1:0], 64'h440100);
      check_output($sformatf("t2_no_serial%0d", c), out_valid, 0);
    end
    check_output("t2_jobs_before", job_count, 16'(exp_jobs));
    fwd_out_ready = 1'b1;
    @(posedge clk);
    #1;
    fwd_out_ready = 1'b0;
    exp_jobs++;
    check_output("t2_jobs_after", job_count, 16'(exp_jobs));
    check_output("t2_fwd_valid_drop", fwd_out_valid, 0);

    // Three back-to-back serial jobs, core delay 20.
    core_delay = 20;
    hbase = hs_data.size();
    dbase = done_cyc_q.size();
    sbase = start_cyc_q.size();
    apply_stimulus(64'h21, NUM_IN);
    apply_stimulus(64'h31, NUM_IN);
    check_output("t3_both_full", in_ready, 0);
    check_output("t3_a_not_done", done_cyc_q.size(), dbase);
    apply_stimulus(64'h41, NUM_IN);
    check_output("t3_c_after_release", (done_cyc_q.size() > dbase), 1);
    wait_hs(hbase + 3 * NUM_OUT);
    check_job("t3a", hbase, 64'h100000);
    check_job("t3b", hbase + NUM_OUT, 64'h200000);
    check_job("t3c", hbase + 2 * NUM_OUT, 64'h300000);
    if (start_cyc_q.size() > sbase + 1 && hs_cyc.size() > hbase + NUM_OUT - 1) begin
      check_output("t3_gap", (start_cyc_q[sbase+1] > hs_cyc[hbase+NUM_OUT-1]), 1);
    end
    @(posedge clk);
    #1;
    exp_jobs += 3;
    check_output("t3_job_count", job_count, 16'(exp_jobs));

    // Toggling out_ready: exactly 18 handshakes, in order.
    core_delay = 5;
    ready_mode = 2;
    hbase = hs_data.size();
    apply_stimulus(64'h11, NUM_IN);
    wait_hs(hbase + NUM_OUT);
    repeat (5) @(posedge clk);
    #1;
    check_output("t4_exact_count", hs_data.size(), hbase + NUM_OUT);
    check_output("t4_idle", out_valid, 0);
    check_job("t4", hbase, 64'h0);
    exp_jobs++;
    check_output("t4_job_count", job_count, 16'(exp_jobs));
    ready_mode = 1;

`ifdef ACC_SHELL_TIMEOUT_EN
    // Core never answers the first job; the queued second job proceeds.
    core_respond = 1'b0;
    hbase = hs_data.size();
    sbase = start_cyc_q.size();
    apply_stimulus(64'h11, NUM_IN);
    apply_stimulus(64'h21, NUM_IN);
    t = 0;
    while (!err_timeout && t < BOUND) begin
      @(posedge clk);
      #1;
      t++;
    end
    core_respond = 1'b1;
    check_output("t5_err", err_timeout, 1);
    if (start_cyc_q.size() > sbase) begin
      check_output("t5_err_lat", 64'(cyc - start_cyc_q[sbase]), 9);
    end
    check_output("t5_jobs_unchanged", job_count, 16'(exp_jobs));
    wait_hs(hbase + NUM_OUT);
    check_job("t5", hbase, 64'h100000);
    @(posedge clk);
    #1;
    exp_jobs++;
    check_output("t5_job_count", job_count, 16'(exp_jobs));
    check_output("t5_err_sticky", err_timeout, 1);
`else
    check_output("t5_err_tied", err_timeout, 0);
`endif

    // Reset in the middle of a serial fill.
    apply_stimulus(64'h99, 2);
    rst_n = 1'b0;
    #1;
    check_output("t6_core_start", core_start, 0);
    check_output("t6_out_valid", out_valid, 0);
    check_output("t6_out_last", out_last, 0);
    check_output("t6_out_data", out_data, 0);
    check_output("t6_fwd_out_valid", fwd_out_valid, 0);
    check_output("t6_fwd_out_data", fwd_out_data[DATA_W-1:0], 0);
    check_output("t6_core_data", core_data[DATA_W-1:0], 0);
    check_output("t6_job_count", job_count, 0);
    check_output("t6_err", err_timeout, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    hbase = hs_data.size();
    apply_stimulus(64'h11, NUM_IN);
    wait_start();
    for (int k = 0; k < NUM_IN; k++) begin
      check_output($sformatf("t6_core_data%0d", k), core_data[k*DATA_W +: DATA_W], 64'h11 * 64'(k + 1));
    end
    wait_hs(hbase + NUM_OUT);
    check_job("t6", hbase, 64'h0);
    @(posedge clk);
    #1;
    check_output("t6_job_after", job_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
